// File: rtl/lvds_pkg.sv
// Shared types and constants for the LVDS word-alignment controller.
package lvds_pkg;

    localparam int LVDS_WORD_W = 8;

    // Training word, LSB received first; all 8 rotations are distinct.
    localparam logic [LVDS_WORD_W-1:0] DEF_TRAIN_PATTERN = 8'h3C;

    typedef enum logic [1:0] {
        HUNT      = 2'd0,
        SLIP_WAIT = 2'd1,
        VERIFY    = 2'd2,
        LOCKED    = 2'd3
    } align_state_t;

endpackage

// File: rtl/lvds_align_ctrl_if.sv
// Serial input and aligned-word output bundle of the LVDS alignment controller.
interface lvds_align_ctrl_if;
    import lvds_pkg::*;

    logic                   lvds_in;
    logic                   train_en;
    logic [LVDS_WORD_W-1:0] word_out;
    logic                   word_valid;
    logic                   locked;
    logic [2:0]             slip_cnt;
    logic                   align_err;

    modport master (
        output lvds_in, train_en,
        input  word_out, word_valid, locked, slip_cnt, align_err
    );

    modport slave (
        input  lvds_in, train_en,
        output word_out, word_valid, locked, slip_cnt, align_err
    );

endinterface

// File: rtl/lvds_deser_slip.sv
// LSB-first 8-bit deserializer; a slip pulse freezes the bit counter for one
// edge, moving the word boundary one bit later.
module lvds_deser_slip
    import lvds_pkg::*;
(
    input  logic                   lvds_clk,
    input  logic                   rst_n,
    input  logic                   lvds_in,
    input  logic                   slip,
    output logic [LVDS_WORD_W-1:0] word_raw,
    output logic                   word_stb
);

    logic [LVDS_WORD_W-1:0] shift_reg;
    logic [LVDS_WORD_W-1:0] shift_nxt;
    logic [2:0]             bit_cnt;
    logic [2:0]             bit_cnt_nxt;
    logic                   capture;

    assign shift_nxt   = {lvds_in, shift_reg[LVDS_WORD_W-1:1]};
    assign bit_cnt_nxt = slip ? bit_cnt : bit_cnt + 3'd1;
    // Counter leaves reset at 7, so it reaches 7 again on the 8th edge.
    assign capture     = !slip && (bit_cnt_nxt == 3'd7);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_reg <= '0;
            bit_cnt   <= 3'd7;
            word_raw  <= '0;
            word_stb  <= 1'b0;
        end else begin
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_cnt_nxt;
            word_stb  <= capture;
            if (capture) word_raw <= shift_nxt;
        end
    end

endmodule

// File: rtl/lvds_align_ctrl.sv
// Word-alignment controller: hunts for the training word by bit-slipping,
// verifies lock over several words, then monitors it while passing data on.
module lvds_align_ctrl
    import lvds_pkg::*;
#(
    parameter logic [LVDS_WORD_W-1:0] TRAIN_PATTERN = DEF_TRAIN_PATTERN,
    parameter int unsigned            VERIFY_CNT    = 4,
    parameter int unsigned            LOSS_CNT      = 3
) (
    input logic              lvds_clk,
    input logic              rst_n,
    lvds_align_ctrl_if.slave bus
);

    localparam logic [3:0] VERIFY_LIM = 4'(VERIFY_CNT);
    localparam logic [3:0] LOSS_LIM   = 4'(LOSS_CNT);

    align_state_t           state, state_nxt;
    logic [3:0]             match_cnt, match_nxt;
    logic [3:0]             miss_cnt, miss_nxt;
    logic [2:0]             fail_cnt, fail_nxt;
    logic [2:0]             slip_cnt, slip_cnt_nxt;
    logic                   slip, slip_nxt;
    logic                   align_err, err_nxt;
    logic [LVDS_WORD_W-1:0] word_out, word_nxt;
    logic                   word_valid, valid_nxt;
    logic [LVDS_WORD_W-1:0] word_raw;
    logic                   word_stb;
    logic                   match;

    lvds_deser_slip u_deser (
        .lvds_clk (lvds_clk),
        .rst_n    (rst_n),
        .lvds_in  (bus.lvds_in),
        .slip     (slip),
        .word_raw (word_raw),
        .word_stb (word_stb)
    );

    assign match = (word_raw == TRAIN_PATTERN);

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_nxt    = state;
        match_nxt    = match_cnt;
        miss_nxt     = miss_cnt;
        fail_nxt     = fail_cnt;
        slip_cnt_nxt = slip_cnt;
        slip_nxt     = 1'b0;
        err_nxt      = 1'b0;
        word_nxt     = word_out;
        valid_nxt    = 1'b0;
        if (word_stb) begin
            unique case (state)
                HUNT: if (bus.train_en) begin
                    if (match) begin
                        state_nxt = (VERIFY_LIM == 4'd1) ? LOCKED : VERIFY;
                        match_nxt = 4'd1;
                    end else begin
                        state_nxt    = SLIP_WAIT;
                        slip_nxt     = 1'b1;
                        slip_cnt_nxt = slip_cnt + 3'd1;
                        // Eighth consecutive failed hunt flags an alignment error.
                        err_nxt      = (fail_cnt == 3'd7);
                        fail_nxt     = fail_cnt + 3'd1;
                    end
                end
                SLIP_WAIT: state_nxt = HUNT;
                VERIFY: if (bus.train_en) begin
                    if (match) begin
                        match_nxt = match_cnt + 4'd1;
                        if (match_cnt + 4'd1 == VERIFY_LIM) begin
                            state_nxt = LOCKED;
                            fail_nxt  = 3'd0;
                            miss_nxt  = 4'd0;
                        end
                    end else begin
                        state_nxt    = SLIP_WAIT;
                        slip_nxt     = 1'b1;
                        slip_cnt_nxt = slip_cnt + 3'd1;
                    end
                end
                LOCKED: begin
                    word_nxt  = word_raw;
                    valid_nxt = 1'b1;
                    if (bus.train_en) begin
                        if (match) begin
                            miss_nxt = 4'd0;
                        end else if (miss_cnt + 4'd1 == LOSS_LIM) begin
                            state_nxt = HUNT;
                            miss_nxt  = 4'd0;
                            word_nxt  = word_out;
                            valid_nxt = 1'b0;
                        end else begin
                            miss_nxt = miss_cnt + 4'd1;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge lvds_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            match_cnt  <= 4'd0;
            miss_cnt   <= 4'd0;
            fail_cnt   <= 3'd0;
            slip_cnt   <= 3'd0;
            slip       <= 1'b0;
            align_err  <= 1'b0;
            word_out   <= '0;
            word_valid <= 1'b0;
        end else begin
            state      <= state_nxt;
            match_cnt  <= match_nxt;
            miss_cnt   <= miss_nxt;
            fail_cnt   <= fail_nxt;
            slip_cnt   <= slip_cnt_nxt;
            slip       <= slip_nxt;
            align_err  <= err_nxt;
            word_out   <= word_nxt;
            word_valid <= valid_nxt;
        end
    end

    assign bus.word_out   = word_out;
    assign bus.word_valid = word_valid;
    assign bus.locked     = (state == LOCKED);
    assign bus.slip_cnt   = slip_cnt;
    assign bus.align_err  = align_err;

endmodule

// File: doc/lvds_align_ctrl.md
# lvds_align_ctrl

Word-alignment controller for the 8-bit LVDS serial-to-parallel receive path. It contains the LSB-first deserializer and adds a bit-slip capability. A framing state machine hunts for a fixed training word, slips the word boundary one bit at a time until the word is found, confirms lock, and then monitors it. Downstream logic consumes `word_out`/`word_valid` only while `locked` is high.

## Interface
- `TRAIN_PATTERN`, 8'h3C: training word, LSB received first. All 8 rotations must be distinct.
- `VERIFY_CNT`, 4: consecutive matching words required to declare lock (1..15).
- `LOSS_CNT`, 3: consecutive mismatches during training that drop lock (1..15).
- `lvds_clk` input 1: bit clock; all logic on its rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `lvds_in` input 1: serial data, LSB first.
- `train_en` input 1: high while the far end transmits `TRAIN_PATTERN`.
- `word_out` output 8: aligned parallel word.
- `word_valid` output 1: one-cycle pulse, `word_out` valid; only while locked.
- `locked` output 1: alignment achieved.
- `slip_cnt` output 3: total slips applied since reset, mod 8.
- `align_err` output 1: one-cycle pulse after 8 consecutive slips without a match.

## Operation
- **Deserializer.**
  - `shift_reg <= {lvds_in, shift_reg[7:1]}` every edge.
  - `bit_cnt` (3 bit) resets to 7 and increments every edge unless `slip` is high, in which case it holds.
  - On an edge with `bit_cnt==7` and no slip: `word_raw <= {lvds_in, shift_reg[7:1]}` and `word_stb <= 1`. Otherwise `word_stb <= 0`.
- **Slip.** `slip` is a registered one-cycle pulse from the FSM. Each slip delays the word boundary by one bit.
- **FSM states:** HUNT, SLIP_WAIT, VERIFY, LOCKED. Reset state is HUNT.
- **HUNT** (acts only on `word_stb` with `train_en=1`):
  - `word_raw==TRAIN_PATTERN`: go to VERIFY, `match_cnt=1`.
  - Otherwise: pulse `slip`, increment `slip_cnt` and `fail_cnt`, go to SLIP_WAIT.
  - When `fail_cnt` reaches 8: pulse `align_err`, clear `fail_cnt`, keep hunting.
- **SLIP_WAIT:** discard the next `word_stb`, then go to HUNT.
- **VERIFY:**
  - Match: `match_cnt++`. When `match_cnt==VERIFY_CNT`, go to LOCKED and clear `fail_cnt`.
  - Mismatch: slip, go to SLIP_WAIT.
  - `train_en=0`: hold state; strobes are ignored.
- **LOCKED:** `locked=1`. On each `word_stb`: `word_out<=word_raw`, `word_valid<=1`.
  - With `train_en=1`, a mismatch increments `miss_cnt` and a match clears it.
  - `miss_cnt==LOSS_CNT`: go to HUNT, `locked` falls, no `word_valid` for that word.
  - With `train_en=0`, no checking is done and `miss_cnt` holds.
- **`train_en` low in HUNT/SLIP_WAIT:** no slips are issued. In SLIP_WAIT the pending discard still completes.
- **Reset asserted mid-operation:** all state returns to reset values immediately; no partial word is emitted.
- **Reset values:** `word_out=0`, `word_valid=0`, `locked=0`, `slip_cnt=0`, `align_err=0`, `bit_cnt=7`, `shift_reg=0`, state HUNT.

## Timing
- The first word captures bits 0..7 after reset release: capture edge is the 8th edge.
- The last bit of a word is sampled at edge N. `word_raw`/`word_stb` update at N. `word_out`/`word_valid`/`slip`/state update at N+1.
- A slip asserted after N+1 freezes `bit_cnt` at edge N+2. The next capture is at N+9 instead of N+8.
- Strobe spacing is 8 cycles, or 9 when a slip intervenes.
- `locked` rises at the same edge as the state change to LOCKED. The first `word_valid` follows on the next strobe.
- Lock loss: `locked` falls at edge N+1 of the `LOSS_CNT`-th mismatching word.

## Structure
- Shared package `lvds_pkg` holds:
  - state enum localparams (HUNT=0, SLIP_WAIT=1, VERIFY=2, LOCKED=3);
  - `LVDS_WORD_W=8`;
  - default `TRAIN_PATTERN`.
- Sub-module `lvds_deser_slip` holds `shift_reg`, `bit_cnt`, `word_raw` and `word_stb`, with a `slip` input. The top level holds the FSM and its counters.

## Test plan
- **Aligned stream.** After reset, continuous 8'h3C with `train_en=1` → 0 slips; `locked` after 4 strobes; `word_out=8'h3C` and `word_valid` every 8 cycles.
- **Late boundary.** Stream offset so the boundary is 3 bits late → exactly 3 slips; `slip_cnt=3`; `locked`; strobe gaps of 9 cycles after each slip.
- **No pattern.** Random data with no 8'h3C rotation → `align_err` pulses after every 8 slips; `locked` stays 0; `slip_cnt` wraps 7→0.
- **Lock loss.** Locked; inject 2 mismatches, then 1 match, then 3 mismatches → lock held through the first 2; drops on the 3rd of the final 3; FSM back to HUNT.
- **Payload traffic.** Locked; `train_en=0` with 8'hFF/8'h00 payload → `locked` stays 1; `word_valid` pulses carry the payload words unchanged.
- **Reset mid-VERIFY.** `rst_n` low for 1 cycle while in VERIFY → all outputs 0; re-lock requires a fresh `VERIFY_CNT` words.
